// File: rtl/stack_arbiter.sv
// stack_arbiter
// Two-requester front end for the 32-entry LIFO stack. Each requester issues
// push/pop transactions on a req/ack handshake. Grants are round-robin, and
// one transaction is in flight at a time. Illegal operations (push when full,
// pop when empty) are acknowledged with an error and never reach the stack.
//
// Ports
//   Clk, Rst             clock, synchronous active-high reset
//   Req0/1, Op0/1        request, operation (1 = push, 0 = pop)
//   Wr_Data0/1           push data, held with Req until Ack
//   Ack0/1, Err0/1       one-cycle completion pulse, reject flag valid with Ack
//   Rd_Data0/1           popped value, held until that port's next ack
//   Stk_Push, Stk_Pop    single-cycle strobes to the stack
//   Stk_Data_In          data to the stack
//   Stk_Data_Out         data from the stack
//   Stk_Full, Stk_Empty  status from the stack
//   Busy                 high whenever the sequencer is not idle
module stack_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req0,
  input  logic             Req1,
  input  logic             Op0,
  input  logic             Op1,
  input  logic [WIDTH-1:0] Wr_Data0,
  input  logic [WIDTH-1:0] Wr_Data1,
  output logic             Ack0,
  output logic             Ack1,
  output logic             Err0,
  output logic             Err1,
  output logic [WIDTH-1:0] Rd_Data0,
  output logic [WIDTH-1:0] Rd_Data1,
  output logic             Stk_Push,
  output logic             Stk_Pop,
  output logic [WIDTH-1:0] Stk_Data_In,
  input  logic [WIDTH-1:0] Stk_Data_Out,
  input  logic             Stk_Full,
  input  logic             Stk_Empty,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic       op_q;

  logic             any_req;
  logic             win;
  logic             win_op;
  logic [WIDTH-1:0] win_data;
  logic             win_legal;

  // Arbitration: a lone requester wins outright; on a tie the port that was
  // not served last wins.
  always_comb begin
    any_req   = Req0 | Req1;
    win       = 1'b0;
    if (Req0 && Req1) win = ~last_grant;
    else              win = Req1;
    win_op    = win ? Op1 : Op0;
    win_data  = win ? Wr_Data1 : Wr_Data0;
    win_legal = win_op ? ~Stk_Full : ~Stk_Empty;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      op_q        <= 1'b0;
      Ack0        <= 1'b0;
      Ack1        <= 1'b0;
      Err0        <= 1'b0;
      Err1        <= 1'b0;
      Rd_Data0    <= '0;
      Rd_Data1    <= '0;
      Stk_Push    <= 1'b0;
      Stk_Pop     <= 1'b0;
      Stk_Data_In <= '0;
      Busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant       <= win;
            op_q        <= win_op;
            Stk_Data_In <= win_data;
            Busy        <= 1'b1;
            if (win_legal) begin
              Stk_Push <= win_op;
              Stk_Pop  <= ~win_op;
              state    <= ISSUE;
            end else begin
              // Rejected: acknowledge with error, stack untouched.
              if (win) begin
                Ack1 <= 1'b1;
                Err1 <= 1'b1;
              end else begin
                Ack0 <= 1'b1;
                Err0 <= 1'b1;
              end
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          Stk_Push <= 1'b0;
          Stk_Pop  <= 1'b0;
          if (op_q) begin
            if (grant) Ack1 <= 1'b1;
            else       Ack0 <= 1'b1;
            state <= DONE;
          end else begin
            // Stack presents the popped word on the edge that ends ISSUE.
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (grant) begin
            Rd_Data1 <= Stk_Data_Out;
            Ack1     <= 1'b1;
          end else begin
            Rd_Data0 <= Stk_Data_Out;
            Ack0     <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          Ack0       <= 1'b0;
          Ack1       <= 1'b0;
          Err0       <= 1'b0;
          Err1       <= 1'b0;
          last_grant <= grant;
          Busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
